fv_bank_stream_ctrl: RTL and testbench

Parametrised feature-vector (FV) bank controller sitting between the FV memory loader, one single-port FV SRAM bank and the Edge-PE array. It accepts burst writes of FV words into the SRAM, queues PE read requests, and streams each requested vector to the tagged PE as sos/eos-framed words. It supports configurable element width and packing, a request queue, output backpressure, masking of unused trailing elements, and address wrap-around.

---
 rtl/fv_bank_stream_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fv_bank_stream_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fv_bank_stream_ctrl.sv
// FV bank controller: accepts burst writes into a single-port FV SRAM and streams
// queued vector reads to tagged Edge PEs as sos/eos-framed words with backpressure.
module fv_bank_stream_ctrl #(
  parameter int unsigned ELEM_W         = 8,
  parameter int unsigned ELEMS_PER_WORD = 2,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned MAX_FV         = 64,
  parameter int unsigned NUM_PE         = 4,
  parameter int unsigned REQ_DEPTH      = 4,
  parameter int unsigned OBUF_DEPTH     = 4,
  localparam int unsigned FV_W = ELEM_W * ELEMS_PER_WORD,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned NW   = $clog2(MAX_FV) + 1,
  localparam int unsigned TW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NW-1:0]   num_fv_i,
  input  logic            wr_valid_i,
  input  logic            wr_sos_i,
  input  logic            wr_eos_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [FV_W-1:0] wr_data_i,
  output logic            wr_ready_o,
  input  logic            rd_req_valid_i,
  input  logic [AW-1:0]   rd_req_addr_i,
  input  logic [TW-1:0]   rd_req_tag_i,
  output logic            rd_req_ready_o,
  output logic            sram_cen_o,
  output logic            sram_wen_o,
  output logic [AW-1:0]   sram_a_o,
  output logic [FV_W-1:0] sram_d_o,
  input  logic [FV_W-1:0] sram_q_i,
  output logic            out_valid_o,
  output logic            out_sos_o,
  output logic            out_eos_o,
  output logic [FV_W-1:0] out_data_o,
  output logic [TW-1:0]   out_tag_o,
  input  logic            out_ready_i,
  output logic            busy_o
);

  localparam int unsigned EPW = ELEMS_PER_WORD;
  localparam int unsigned QPW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned QCW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned OPW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned OCW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StStream, StDrain} state_e;

  function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
    return (p == QPW'(REQ_DEPTH - 1)) ? '0 : p + QPW'(1);
  endfunction

  function automatic logic [OPW-1:0] ob_inc(input logic [OPW-1:0] p);
    return (p == OPW'(OBUF_DEPTH - 1)) ? '0 : p + OPW'(1);
  endfunction

  function automatic logic [AW-1:0] a_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Elements at index >= rem are dropped from the last word; rem == 0 keeps all.
  function automatic logic [EPW-1:0] keep_mask(input logic [NW-1:0] rem);
    logic [EPW-1:0] m;
    for (int unsigned e = 0; e < EPW; e++) m[e] = (rem == '0) || (32'(rem) > e);
    return m;
  endfunction

  state_e          state_q;
  logic            sram_cen_q, sram_wen_q;
  logic [AW-1:0]   sram_a_q;
  logic [FV_W-1:0] sram_d_q;

  // Request queue
  logic [AW-1:0]  q_addr_q [REQ_DEPTH];
  logic [TW-1:0]  q_tag_q  [REQ_DEPTH];
  logic [QPW-1:0] q_wptr_q, q_rptr_q;
  logic [QCW-1:0] q_cnt_q;
  logic           q_push, q_pop;

  // Vector context and read pipeline (pins stage, then SRAM data stage)
  logic [AW-1:0]  rd_addr_q;
  logic [NW-1:0]  widx_q, words_q;
  logic [EPW-1:0] keep_last_q;
  logic [TW-1:0]  tag_q;
  logic           rd_pin_q, pin_sos_q, pin_eos_q;
  logic [EPW-1:0] pin_keep_q;
  logic           rd_dat_q, dat_sos_q, dat_eos_q;
  logic [EPW-1:0] dat_keep_q;

  // Output buffer
  logic [FV_W-1:0] ob_data_q [OBUF_DEPTH];
  logic            ob_sos_q  [OBUF_DEPTH];
  logic            ob_eos_q  [OBUF_DEPTH];
  logic [TW-1:0]   ob_tag_q  [OBUF_DEPTH];
  logic [OPW-1:0]  ob_wptr_q, ob_rptr_q;
  logic [OCW-1:0]  ob_cnt_q, ob_cnt_d;
  logic            out_valid_q, ob_push, ob_pop;

  logic            start_wr, can_issue, stream_eos;
  logic [31:0]     credit_used;
  logic [NW-1:0]   pop_words, pop_rem;
  logic [FV_W-1:0] cap_data;

  assign rd_req_ready_o = (q_cnt_q != QCW'(REQ_DEPTH));
  assign q_push         = rd_req_valid_i & rd_req_ready_o;
  assign start_wr       = (state_q == StIdle) & wr_valid_i & wr_sos_i;
  assign q_pop          = (state_q == StIdle) & !start_wr & (q_cnt_q != '0);
  assign pop_words      = NW'((32'(num_fv_i) + EPW - 1) / EPW);
  assign pop_rem        = NW'(32'(num_fv_i) % EPW);
  // Reserve buffer room for every read already on the pins or returning from the SRAM.
  assign credit_used    = 32'(ob_cnt_q) + 32'(rd_pin_q) + 32'(rd_dat_q);
  assign can_issue      = credit_used < OBUF_DEPTH;
  assign stream_eos     = (widx_q == words_q - NW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      q_wptr_q <= '0;
      q_rptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (q_push) q_wptr_q <= q_inc(q_wptr_q);
      if (q_pop)  q_rptr_q <= q_inc(q_rptr_q);
      if (q_push && !q_pop)      q_cnt_q <= q_cnt_q + QCW'(1);
      else if (!q_push && q_pop) q_cnt_q <= q_cnt_q - QCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_addr_q[q_wptr_q] <= rd_req_addr_i;
      q_tag_q[q_wptr_q]  <= rd_req_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sram_cen_q  <= 1'b1;
      sram_wen_q  <= 1'b1;
      sram_a_q    <= '0;
      sram_d_q    <= '0;
      rd_addr_q   <= '0;
      widx_q      <= '0;
      words_q     <= '0;
      keep_last_q <= '0;
      tag_q       <= '0;
      rd_pin_q    <= 1'b0;
      pin_sos_q   <= 1'b0;
      pin_eos_q   <= 1'b0;
      pin_keep_q  <= '0;
    end else begin
      sram_cen_q <= 1'b1;
      sram_wen_q <= 1'b1;
      rd_pin_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_wr) begin
            sram_cen_q <= 1'b0;
            sram_wen_q <= 1'b0;
            sram_a_q   <= wr_addr_i;
            sram_d_q   <= wr_data_i;
            if (!wr_eos_i) state_q <= StWrite;
          end else if (q_pop) begin
            tag_q       <= q_tag_q[q_rptr_q];
            words_q     <= pop_words;
            keep_last_q <= keep_mask(pop_rem);
            // Zero-length requests are consumed without touching the SRAM.
            if (pop_words != '0) begin
              sram_cen_q <= 1'b0;
              sram_a_q   <= q_addr_q[q_rptr_q];
              rd_pin_q   <= 1'b1;
              pin_sos_q  <= 1'b1;
              pin_eos_q  <= (pop_words == NW'(1));
              pin_keep_q <= (pop_words == NW'(1)) ? keep_mask(pop_rem) : '1;
              rd_addr_q  <= a_inc(q_addr_q[q_rptr_q]);
              widx_q     <= NW'(1);
              state_q    <= (pop_words == NW'(1)) ? StDrain : StStream;
            end
          end
        end
        StWrite: begin
          if (wr_valid_i) begin
            sram_cen_q <= 1'b0;
            sram_wen_q <= 1'b0;
            sram_a_q   <= wr_addr_i;
            sram_d_q   <= wr_data_i;
            if (wr_eos_i) state_q <= StIdle;
          end
        end
        StStream: begin
          if (can_issue) begin
            sram_cen_q <= 1'b0;
            sram_a_q   <= rd_addr_q;
            rd_pin_q   <= 1'b1;
            pin_sos_q  <= 1'b0;
            pin_eos_q  <= stream_eos;
            pin_keep_q <= stream_eos ? keep_last_q : '1;
            rd_addr_q  <= a_inc(rd_addr_q);
            widx_q     <= widx_q + NW'(1);
            if (stream_eos) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!rd_pin_q && !rd_dat_q && ob_cnt_q == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_dat_q   <= 1'b0;
      dat_sos_q  <= 1'b0;
      dat_eos_q  <= 1'b0;
      dat_keep_q <= '0;
    end else begin
      rd_dat_q   <= rd_pin_q;
      dat_sos_q  <= pin_sos_q;
      dat_eos_q  <= pin_eos_q;
      dat_keep_q <= pin_keep_q;
    end
  end

  always_comb begin
    cap_data = sram_q_i;
    for (int unsigned e = 0; e < EPW; e++) begin
      if (!dat_keep_q[e]) cap_data[e*ELEM_W +: ELEM_W] = '0;
    end
  end

  always_comb begin
    ob_push  = rd_dat_q;
    ob_pop   = out_valid_q & out_ready_i;
    ob_cnt_d = ob_cnt_q;
    if (ob_push && !ob_pop)      ob_cnt_d = ob_cnt_q + OCW'(1);
    else if (!ob_push && ob_pop) ob_cnt_d = ob_cnt_q - OCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ob_wptr_q   <= '0;
      ob_rptr_q   <= '0;
      ob_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        ob_data_q[i] <= '0;
        ob_sos_q[i]  <= 1'b0;
        ob_eos_q[i]  <= 1'b0;
        ob_tag_q[i]  <= '0;
      end
    end else begin
      ob_cnt_q    <= ob_cnt_d;
      out_valid_q <= (ob_cnt_d != '0);
      if (ob_pop) ob_rptr_q <= ob_inc(ob_rptr_q);
      if (ob_push) begin
        ob_data_q[ob_wptr_q] <= cap_data;
        ob_sos_q[ob_wptr_q]  <= dat_sos_q;
        ob_eos_q[ob_wptr_q]  <= dat_eos_q;
        ob_tag_q[ob_wptr_q]  <= tag_q;
        ob_wptr_q            <= ob_inc(ob_wptr_q);
      end
    end
  end

  assign sram_cen_o  = sram_cen_q;
  assign sram_wen_o  = sram_wen_q;
  assign sram_a_o    = sram_a_q;
  assign sram_d_o    = sram_d_q;
  assign out_valid_o = out_valid_q;
  assign out_sos_o   = ob_sos_q[ob_rptr_q];
  assign out_eos_o   = ob_eos_q[ob_rptr_q];
  assign out_data_o  = ob_data_q[ob_rptr_q];
  assign out_tag_o   = ob_tag_q[ob_rptr_q];
  assign wr_ready_o  = (state_q == StIdle) | (state_q == StWrite);
  assign busy_o      = (state_q != StIdle) | (q_cnt_q != '0);

endmodule

// File: tb/tb_fv_bank_stream_ctrl.sv
// Directed bench for fv_bank_stream_ctrl: table of stream vectors plus hand-written
// sequences for writes, zero-length, backpressure, queue ordering and reset.
`timescale 1ns/1ps
module tb_fv_bank_stream_ctrl;
  localparam int unsigned AW = 8, FV_W = 16, NW = 7, TW = 2, OBUF = 4;

  logic            clk = 1'b0, reset = 1'b1;
  logic [NW-1:0]   num_fv = '0;
  logic            wr_valid = 1'b0, wr_sos = 1'b0, wr_eos = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [FV_W-1:0] wr_data = '0;
  logic            wr_ready;
  logic            rd_req_valid = 1'b0;
  logic [AW-1:0]   rd_req_addr = '0;
  logic [TW-1:0]   rd_req_tag = '0;
  logic            rd_req_ready;
  logic            sram_cen, sram_wen;
  logic [AW-1:0]   sram_a;
  logic [FV_W-1:0] sram_d, sram_q;
  logic            out_valid, out_sos, out_eos;
  logic [FV_W-1:0] out_data;
  logic [TW-1:0]   out_tag;
  logic            out_ready = 1'b1;
  logic            busy;

  fv_bank_stream_ctrl dut (
    .clk(clk), .reset(reset), .num_fv_i(num_fv),
    .wr_valid_i(wr_valid), .wr_sos_i(wr_sos), .wr_eos_i(wr_eos),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_req_valid_i(rd_req_valid), .rd_req_addr_i(rd_req_addr), .rd_req_tag_i(rd_req_tag),
    .rd_req_ready_o(rd_req_ready),
    .sram_cen_o(sram_cen), .sram_wen_o(sram_wen), .sram_a_o(sram_a), .sram_d_o(sram_d),
    .sram_q_i(sram_q),
    .out_valid_o(out_valid), .out_sos_o(out_sos), .out_eos_o(out_eos),
    .out_data_o(out_data), .out_tag_o(out_tag), .out_ready_i(out_ready),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [FV_W-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_cen == 1'b0) begin
      if (sram_wen == 1'b0) sram_mem[sram_a] <= sram_d;
      else                  sram_q <= sram_mem[sram_a];
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_beat(input logic [AW-1:0] a, input logic [FV_W-1:0] d,
                         input logic s, input logic e);
    wr_valid = 1'b1; wr_sos = s; wr_eos = e; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0; wr_sos = 1'b0; wr_eos = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 40) begin step(); k++; end
    chk({nm, " idle"}, busy, 0);
    chk({nm, " no extra word"}, out_valid, 0);
  endtask

  task automatic expect_word(input string nm, input logic [FV_W-1:0] d, input logic [TW-1:0] t,
                             input logic s, input logic e);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    chk({nm, " valid"}, out_valid, 1);
    chk({nm, " data"}, out_data, d);
    chk({nm, " tag"}, out_tag, t);
    chk({nm, " sos"}, out_sos, s);
    chk({nm, " eos"}, out_eos, e);
    step();
  endtask

  typedef struct packed {
    logic [AW-1:0]          addr;
    logic [NW-1:0]          nfv;
    logic [TW-1:0]          tag;
    logic [1:0]             nw;
    logic [2:0][FV_W-1:0]   exp;
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int i, input logic [AW-1:0] a, input logic [NW-1:0] n,
                         input logic [TW-1:0] t, input logic [1:0] nw,
                         input logic [FV_W-1:0] e0, input logic [FV_W-1:0] e1,
                         input logic [FV_W-1:0] e2);
    vecs[i].addr = a; vecs[i].nfv = n; vecs[i].tag = t; vecs[i].nw = nw;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got, reads, maxout, stall, cyc;
    bit any;

    for (int i = 0; i < 256; i++) sram_mem[i] = '0;

    set_vec(0, 8'd0,   7'd5, 2'd2, 2'd3, 16'hAA01, 16'hBB02, 16'h0003);
    set_vec(1, 8'd0,   7'd1, 2'd1, 2'd1, 16'h0001, 16'h0000, 16'h0000);
    set_vec(2, 8'd1,   7'd2, 2'd3, 2'd1, 16'hBB02, 16'h0000, 16'h0000);
    set_vec(3, 8'd255, 7'd4, 2'd0, 2'd2, 16'hEE05, 16'hAA01, 16'h0000);
    set_vec(4, 8'd255, 7'd3, 2'd1, 2'd2, 16'hEE05, 16'h0001, 16'h0000);
    set_vec(5, 8'd1,   7'd6, 2'd2, 2'd3, 16'hBB02, 16'hCC03, 16'hDD04);
    set_vec(6, 8'd5,   7'd5, 2'd3, 2'd3, 16'h1111, 16'h2222, 16'h0033);

    // Reset values
    step(); step();
    chk("rst cen", sram_cen, 1);
    chk("rst wen", sram_wen, 1);
    chk("rst a", sram_a, 0);
    chk("rst d", sram_d, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst busy", busy, 0);
    chk("rst rd_req_ready", rd_req_ready, 1);
    chk("rst wr_ready", wr_ready, 1);
    reset = 1'b0;
    step();

    // Beat without sos in IDLE is ignored
    wr_beat(8'd40, 16'hDEAD, 1'b0, 1'b0);
    chk("nosos cen", sram_cen, 1);
    chk("nosos busy", busy, 0);

    // Write burst 5,6,gap,7
    wr_beat(8'd5, 16'h1111, 1'b1, 1'b0);
    chk("wr0 cen", sram_cen, 0); chk("wr0 wen", sram_wen, 0);
    chk("wr0 a", sram_a, 5);     chk("wr0 d", sram_d, 16'h1111);
    chk("wr0 busy", busy, 1);
    wr_beat(8'd6, 16'h2222, 1'b0, 1'b0);
    chk("wr1 cen", sram_cen, 0); chk("wr1 a", sram_a, 6); chk("wr1 d", sram_d, 16'h2222);
    chk("wr1 wr_ready", wr_ready, 1);
    step();
    chk("wr gap cen", sram_cen, 1);
    wr_beat(8'd7, 16'h3333, 1'b0, 1'b1);
    chk("wr2 cen", sram_cen, 0); chk("wr2 wen", sram_wen, 0);
    chk("wr2 a", sram_a, 7);     chk("wr2 d", sram_d, 16'h3333);
    chk("wr eos idle", busy, 0);
    step();
    chk("wr after cen", sram_cen, 1);

    // Preload vectors
    wr_beat(8'd0, 16'hAA01, 1'b1, 1'b0);
    wr_beat(8'd1, 16'hBB02, 1'b0, 1'b0);
    wr_beat(8'd2, 16'hCC03, 1'b0, 1'b0);
    wr_beat(8'd3, 16'hDD04, 1'b0, 1'b0);
    wr_beat(8'd255, 16'hEE05, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      wr_beat(8'(16 + k), 16'h5000 + 16'(k), (k == 0), (k == 7));
    step();

    // Table-driven stream vectors at full throughput
    for (int v = 0; v < 7; v++) begin
      num_fv = vecs[v].nfv; rd_req_addr = vecs[v].addr; rd_req_tag = vecs[v].tag;
      rd_req_valid = 1'b1;
      step();
      rd_req_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin step(); lat++; end
      chk($sformatf("v%0d latency", v), lat, 4);
      for (int w = 0; w < int'(vecs[v].nw); w++) begin
        chk($sformatf("v%0d w%0d valid", v, w), out_valid, 1);
        chk($sformatf("v%0d w%0d data", v, w), out_data, vecs[v].exp[w]);
        chk($sformatf("v%0d w%0d sos", v, w), out_sos, (w == 0));
        chk($sformatf("v%0d w%0d eos", v, w), out_eos, (w == int'(vecs[v].nw) - 1));
        chk($sformatf("v%0d w%0d tag", v, w), out_tag, vecs[v].tag);
        step();
      end
      wait_idle($sformatf("v%0d", v));
    end

    // Zero-length request is dropped
    num_fv = 7'd0; rd_req_addr = 8'd0; rd_req_tag = 2'd1; rd_req_valid = 1'b1;
    step();
    rd_req_valid = 1'b0;
    chk("nfv0 busy queued", busy, 1);
    step();
    chk("nfv0 busy drops", busy, 0);
    chk("nfv0 cen", sram_cen, 1);
    any = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); if (out_valid) any = 1'b1; end
    chk("nfv0 no output", any, 0);

    // Backpressure mid-vector: 16 elements = 8 words
    num_fv = 7'd16; rd_req_addr = 8'd16; rd_req_tag = 2'd3; rd_req_valid = 1'b1;
    step();
    rd_req_valid = 1'b0;
    got = 0; reads = 0; maxout = 0; stall = 0; cyc = 0;
    while (got < 8 && cyc < 100) begin
      if (!sram_cen && sram_wen) reads++;
      if (reads - got > maxout) maxout = reads - got;
      if (got == 2 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
        if (stall == 5) begin
          chk("bp stalled cen", sram_cen, 1);
          chk("bp hold valid", out_valid, 1);
          chk("bp hold data", out_data, 16'h5002);
          chk("bp hold sos", out_sos, 0);
        end
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp w%0d data", got), out_data, 16'h5000 + 16'(got));
        chk($sformatf("bp w%0d sos", got), out_sos, (got == 0));
        chk($sformatf("bp w%0d eos", got), out_eos, (got == 7));
        chk($sformatf("bp w%0d tag", got), out_tag, 3);
        got++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    chk("bp words delivered", got, 8);
    chk("bp outstanding within buffer", (maxout <= OBUF), 1);
    chk("bp reads issued", reads, 8);
    wait_idle("bp");

    // Queue: fill during a write burst, write start beats pending pop
    num_fv = 7'd2;
    wr_beat(8'd8, 16'h0808, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_req_addr = 8'(i); rd_req_tag = 2'(i); rd_req_valid = 1'b1;
      chk($sformatf("q ready %0d", i), rd_req_ready, 1);
      step();
    end
    rd_req_addr = 8'd0; rd_req_tag = 2'd0;
    chk("q full ready", rd_req_ready, 0);
    wr_valid = 1'b1; wr_sos = 1'b0; wr_eos = 1'b1; wr_addr = 8'd9; wr_data = 16'h0909;
    step();
    wr_valid = 1'b1; wr_sos = 1'b1; wr_eos = 1'b1; wr_addr = 8'd10; wr_data = 16'h0A0A;
    chk("q full ready idle", rd_req_ready, 0);
    step();
    wr_valid = 1'b0; wr_sos = 1'b0; wr_eos = 1'b0;
    chk("q write wins cen", sram_cen, 0);
    chk("q write wins wen", sram_wen, 0);
    chk("q write wins a", sram_a, 10);
    chk("q still full", rd_req_ready, 0);
    step();
    chk("q ready after pop", rd_req_ready, 1);
    chk("q first read cen", sram_cen, 0);
    chk("q first read wen", sram_wen, 1);
    chk("q first read a", sram_a, 0);
    step();
    rd_req_valid = 1'b0;
    expect_word("q0", 16'hAA01, 2'd0, 1'b1, 1'b1);
    expect_word("q1", 16'hBB02, 2'd1, 1'b1, 1'b1);
    expect_word("q2", 16'hCC03, 2'd2, 1'b1, 1'b1);
    expect_word("q3", 16'hDD04, 2'd3, 1'b1, 1'b1);
    expect_word("q4", 16'hAA01, 2'd0, 1'b1, 1'b1);
    wait_idle("q");

    // Reset during STREAM
    num_fv = 7'd16; rd_req_addr = 8'd16; rd_req_tag = 2'd1; rd_req_valid = 1'b1;
    step();
    rd_req_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk("rs stream started", out_valid, 1);
    step();
    reset = 1'b1;
    step();
    chk("rs cen", sram_cen, 1);
    chk("rs wen", sram_wen, 1);
    chk("rs a", sram_a, 0);
    chk("rs d", sram_d, 0);
    chk("rs out_valid", out_valid, 0);
    chk("rs out_sos", out_sos, 0);
    chk("rs out_eos", out_eos, 0);
    chk("rs out_data", out_data, 0);
    chk("rs out_tag", out_tag, 0);
    chk("rs busy", busy, 0);
    chk("rs rd_req_ready", rd_req_ready, 1);
    chk("rs wr_ready", wr_ready, 1);
    reset = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid || !sram_cen) any = 1'b1;
    end
    chk("rs no activity after reset", any, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
